// File: rtl/ndn_rx_packet_assembler_pkg.sv
// Shared types and constants for the NDN MCU packet receive path.
package ndn_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREFIX,
        PAYLOAD,
        DROP
    } state_t;

    localparam logic PKT_TYPE_INTEREST = 1'b0;
    localparam logic PKT_TYPE_DATA     = 1'b1;
    localparam int   META_TYPE_BIT     = 7;
    localparam int   PREFIX_BYTES      = 8;

endpackage

// File: rtl/ndn_rx_packet_assembler_fifo.sv
// Registered first-word-fall-through FIFO; head word is visible while valid.
module ndn_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = valid & ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign data    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ndn_rx_packet_assembler.sv
// Frames spi_mcu RX bytes into header + payload FIFO.
// Optional inter-byte timeout: define NDN_RX_TIMEOUT_EN.
module ndn_rx_packet_assembler
    import ndn_pkt_pkg::*;
#(
    parameter int PREFIX_W       = PREFIX_BYTES * 8,
    parameter int LEN_W          = 6,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid,
    input  logic [7:0]          rx_byte,
    output logic                hdr_valid,
    input  logic                hdr_ready,
    output logic                hdr_type,
    output logic [LEN_W-1:0]    hdr_length,
    output logic [PREFIX_W-1:0] hdr_prefix,
    output logic                pay_valid,
    input  logic                pay_ready,
    output logic [7:0]          pay_data,
    output logic                pay_last,
    output logic                overflow,
    output logic [7:0]          drop_count,
    output logic                busy
);

    localparam int PB    = PREFIX_W / 8;
    localparam int CNT_W = $clog2(PB);
    localparam int REM_W = $clog2(PB + (1 << LEN_W));

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] byte_cnt;
    logic [REM_W-1:0] remaining;
    logic [LEN_W-1:0] len_field;
    logic             prefix_done;
    logic             timeout;
    logic             push;
    logic             push_last;
    logic             fifo_full;
    logic             pay_pop;
    logic             drop_evt;

    assign len_field   = rx_byte[LEN_W-1:0];
    assign prefix_done = rx_valid && (state == PREFIX)
                         && (byte_cnt == CNT_W'(PB - 1));
    assign pay_pop     = pay_valid & pay_ready;
    assign drop_evt    = (rx_valid && state == IDLE && hdr_valid)
                         || timeout;

`ifdef NDN_RX_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] gap;

    always_ff @(posedge clk) begin
        if (rst || state == IDLE || rx_valid) gap <= '0;
        else                                  gap <= gap + 1'b1;
    end

    assign timeout = (state != IDLE) && !rx_valid
                     && (gap == GAP_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the gap counter a stalled packet simply waits.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (rx_valid) state_nx = hdr_valid ? DROP : PREFIX;
            PREFIX:
                if (prefix_done)
                    state_nx = (hdr_length != '0) ? PAYLOAD : IDLE;
            PAYLOAD, DROP:
                if (rx_valid && remaining == REM_W'(1)) state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
        if (timeout) state_nx = IDLE;
    end

    always_comb begin
        busy      = (state != IDLE);
        push      = rx_valid && (state == PAYLOAD);
        push_last = (remaining == REM_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_valid  <= 1'b0;
            hdr_type   <= PKT_TYPE_INTEREST;
            hdr_length <= '0;
            hdr_prefix <= '0;
            byte_cnt   <= '0;
            remaining  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (hdr_valid && hdr_ready) hdr_valid <= 1'b0;
            if (rx_valid && state == IDLE) begin
                if (!hdr_valid) begin
                    hdr_type   <= rx_byte[META_TYPE_BIT] ? PKT_TYPE_DATA
                                                         : PKT_TYPE_INTEREST;
                    hdr_length <= len_field;
                    byte_cnt   <= '0;
                end else begin
                    remaining <= REM_W'(PB) + REM_W'(len_field);
                end
            end
            if (rx_valid && state == PREFIX) begin
                hdr_prefix <= {hdr_prefix[PREFIX_W-9:0], rx_byte};
                byte_cnt   <= byte_cnt + 1'b1;
                if (prefix_done) begin
                    hdr_valid <= 1'b1;
                    remaining <= REM_W'(hdr_length);
                end
            end
            if (rx_valid && (state == PAYLOAD || state == DROP))
                remaining <= remaining - REM_W'(1);
            if (push && fifo_full && !pay_pop) overflow <= 1'b1;
            if (drop_evt && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    ndn_byte_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({push_last, rx_byte}),
        .full      (fifo_full),
        .valid     (pay_valid),
        .ready     (pay_ready),
        .data      ({pay_last, pay_data})
    );

endmodule

// File: doc/ndn_rx_packet_assembler.md
Name: ndn_rx_packet_assembler

Overview:
- Sits directly downstream of spi_mcu.
- Consumes its per-byte RX stream (RX_valid pulse plus output_shift_register byte) and frames MCU packets: 1 meta byte, 8 prefix bytes (MSB first), then N payload bytes.
- Presents a parsed header (type, length, 64-bit prefix) to the PIT/FIB lookup via valid/ready.
- Buffers payload bytes in a small FIFO with valid/ready, because spi_mcu cannot be back-pressured.

Parameters:
- PREFIX_W, 64, prefix width in bits; must be a multiple of 8.
- LEN_W, 6, payload length field width.
- FIFO_DEPTH, 16, payload FIFO entries; power of two.
- TIMEOUT_CYCLES, 1024, inter-byte gap limit; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse from spi_mcu: byte ready.
- rx_byte  in  8  byte from spi_mcu output_shift_register.
- hdr_valid  out  1  parsed header available.
- hdr_ready  in  1  consumer accepts header.
- hdr_type  out  1  0 = interest, 1 = data.
- hdr_length  out  LEN_W  payload byte count.
- hdr_prefix  out  PREFIX_W  name prefix.
- pay_valid  out  1  FIFO not empty.
- pay_ready  in  1  consumer pops a payload byte.
- pay_data  out  8  FIFO head byte.
- pay_last  out  1  head byte is the final payload byte of its packet.
- overflow  out  1  sticky: a payload byte was lost because the FIFO was full.
- drop_count  out  8  saturating count of dropped packets.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: every output is 0, FIFO is emptied, state is IDLE, counters are 0. Reset mid-packet abandons the packet; the next byte after reset is treated as a meta byte.
- Meta byte layout: bit7 = type, bit6 reserved and ignored, bits[LEN_W-1:0] = length.
- Only cycles with rx_valid=1 advance parsing. When rx_valid=0 the block holds its state, except for the optional timeout.
- State IDLE, on rx_valid:
  - hdr_valid=0: latch type and length, go to PREFIX with byte_cnt=0.
  - hdr_valid=1 (previous header not yet taken): go to DROP, load the remaining-bytes count with 8+length, increment drop_count (saturates at 255).
- State PREFIX:
  - Each byte is shifted in: prefix = {prefix[PREFIX_W-9:0], byte}.
  - On the 8th byte, hdr_valid is set high starting the next cycle. Go to PAYLOAD if length>0, else IDLE.
- State PAYLOAD:
  - Each byte is pushed to the FIFO with last=1 when the remaining count is 1; remaining is decremented.
  - Return to IDLE once remaining reaches 0.
  - A byte arriving with the FIFO full is discarded and overflow is set. The count still decrements.
  - If that discarded byte carried last=1, pay_last for the packet is lost; this is acceptable because overflow flags the error.
- State DROP: consumes bytes without storing them until the remaining count reaches 0, then returns to IDLE.
- Header handshake:
  - hdr_valid stays high with stable hdr_type, hdr_length and hdr_prefix until a cycle with hdr_valid & hdr_ready. It clears in the following cycle.
  - The header registers load only from IDLE/PREFIX, so a held header is never overwritten.
- FIFO:
  - Registered first-word-fall-through, 9 bits wide (data plus last).
  - Pop occurs when pay_valid & pay_ready.
  - Simultaneous push and pop when full is allowed: the push succeeds because the pop frees the slot in the same cycle.
  - Push to empty: pay_valid goes high the next cycle, giving 1-cycle latency.
- Occupancy counter is width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: NDN_RX_TIMEOUT_EN.
- Defined:
  - A gap counter runs while state is not IDLE and resets on each rx_valid.
  - When it reaches TIMEOUT_CYCLES the FSM returns to IDLE and drop_count increments.
  - FIFO bytes already pushed stay in the FIFO; the partial packet's last byte is never marked.
  - A header already raised is kept.
- Undefined: no counter exists, and a stalled packet waits indefinitely.

Decomposition:
- Package ndn_pkt_pkg holds:
  - state enum: IDLE, PREFIX, PAYLOAD, DROP;
  - PKT_TYPE_INTEREST=0 and PKT_TYPE_DATA=1;
  - META_TYPE_BIT=7;
  - PREFIX_BYTES=8.
- Sub-module: ndn_byte_fifo, a parameterised FWFT FIFO with width and depth parameters.

Test Plan:
- Meta byte 0x83, prefix 0x0000000000000081, payload "abc" with hdr_ready=1 -> hdr_valid for 1 cycle with type=1, length=3, prefix=0x81; FIFO yields 'a','b','c' with pay_last only on 'c'.
- Meta byte 0x00 plus 8 prefix bytes, length 0 -> header raised, no FIFO push, busy low after the 9th byte.
- Hold hdr_ready=0, then send a second complete packet -> header 1 stays stable, second packet dropped, drop_count=1, FIFO holds only packet-1 payload.
- pay_ready=0 and a 20-byte payload with FIFO_DEPTH=16 -> 16 bytes stored, overflow=1, state back in IDLE after byte 20.
- Assert rst after the 4th prefix byte, then send a fresh packet -> fresh packet parsed correctly with all outputs cleared in between.
- With NDN_RX_TIMEOUT_EN defined and TIMEOUT_CYCLES=32: stop after 2 prefix bytes -> IDLE after 32 idle cycles, drop_count=1, the next packet parses correctly.
